// File: rtl/riscv_mem_pkg.sv
// Shared data-memory types: request bundle, port owner encoding, dmem geometry.
package riscv_mem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_RD_LAT = 1;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DBG
    } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Priority decision for the dmem port: core first, debug when locked,
// alone, or starved for MAX_WAIT consecutive cycles.
module dmem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic             core_req,
    input  logic             dbg_req,
    input  logic             lock_q,
    input  logic [CNT_W-1:0] wait_cnt_q,
    output owner_e           owner
);

    logic starved;

    assign starved = (wait_cnt_q >= CNT_W'(MAX_WAIT));

    // A locked debug master keeps the port only while it is still requesting;
    // an idle locked cycle falls through so the core can win immediately.
    always_comb begin
        owner = OWN_NONE;
        if (dbg_req && (lock_q || !core_req || starved)) begin
            owner = OWN_DBG;
        end else if (core_req) begin
            owner = OWN_CORE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter for the single dmem port shared by the core memory stage and the
// debug/loader port. Holds the lock, starvation counter and read-return owner.
module dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    logic                   lock_q, lock_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic [DMEM_RD_LAT-1:0] rd_owner_q, rd_owner_d, rd_issue;
    owner_e                 owner_raw, owner;
    mem_req_t               win_req;
    logic                   unused_addr_hi;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_pick (
        .core_req   (core_req),
        .dbg_req    (dbg_req),
        .lock_q     (lock_q),
        .wait_cnt_q (wait_cnt_q),
        .owner      (owner_raw)
    );

    // Reset forces the port idle so nothing reaches dmem while state is cleared.
    assign owner      = reset ? OWN_NONE : owner_raw;
    assign core_stall = core_req && !reset && (owner != OWN_CORE);
    assign dbg_gnt    = dbg_req && (owner == OWN_DBG);

    // Route the winner's request to dmem; an idle port drives all zeros.
    always_comb begin
        win_req = '0;
        case (owner)
            OWN_CORE: win_req = '{we: core_we, be: core_be, addr: core_addr, wdata: core_wdata};
            OWN_DBG:  win_req = '{we: dbg_we,  be: dbg_be,  addr: dbg_addr,  wdata: dbg_wdata};
            default:  win_req = '0;
        endcase
    end

    assign mem_we         = win_req.we;
    assign mem_be         = win_req.be;
    assign mem_a          = win_req.addr[ADDR_W-1:0];
    assign mem_wd         = win_req.wdata;
    assign unused_addr_hi = ^win_req.addr[31:ADDR_W];

    // dmem read data is registered, so the core sees it raw and debug only
    // when its own read was issued DMEM_RD_LAT cycles ago.
    assign core_rdata = reset ? '0 : mem_rd;
    assign dbg_rvalid = rd_owner_q[DMEM_RD_LAT-1] && !reset;
    assign dbg_rdata  = dbg_rvalid ? mem_rd : '0;

    // Next-state for lock, starvation counter and read-return tracking.
    always_comb begin
        lock_d = lock_q;
        if (dbg_gnt && dbg_lock) begin
            lock_d = 1'b1;
        end else if (lock_q && (!dbg_req || !dbg_lock)) begin
            lock_d = 1'b0;
        end

        wait_cnt_d = '0;
        if (dbg_req && !dbg_gnt) begin
            wait_cnt_d = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        rd_issue    = '0;
        rd_issue[0] = dbg_gnt && !dbg_we;
        rd_owner_d  = (rd_owner_q << 1) | rd_issue;
    end

    // State registers; reset drops the lock and any pending debug read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            wait_cnt_q <= '0;
            rd_owner_q <= '0;
        end else begin
            lock_q     <= lock_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a registered dmem model and a
// read-return scoreboard.
module tb_dmem_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [3:0]    core_be, dbg_be;
    logic [31:0]   core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [31:0]   core_rdata, dbg_rdata, mem_wd, mem_rd;
    logic          core_stall, dbg_gnt, dbg_rvalid, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_a;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_be(core_be),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Registered-read byte-writable data memory.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_a[9:2]][b*8 +: 8] <= mem_wd[b*8 +: 8];
        mem_rd <= ram[mem_a[9:2]];
    end

    typedef struct {
        logic creq, cwe; logic [31:0] caddr, cwd;
        logic dreq, dwe, dlock; logic [31:0] daddr, dwd;
        logic stall, gnt; logic [AW-1:0] a; logic we; logic [3:0] be; logic [31:0] wd;
        logic chk_cd; logic [31:0] cd;
        logic chk_dd; logic [31:0] dd;
    } vec_t;

    typedef struct { int due; bit is_dbg; logic [31:0] data; } sb_t;
    sb_t sbq[$];

    function automatic vec_t mk(
        input logic creq, cwe, input logic [31:0] caddr, cwd,
        input logic dreq, dwe, dlock, input logic [31:0] daddr, dwd,
        input logic stall, gnt, input logic [AW-1:0] a, input logic we,
        input logic [3:0] be, input logic [31:0] wd,
        input logic chk_cd, input logic [31:0] cd, input logic chk_dd, input logic [31:0] dd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
        v.stall = stall; v.gnt = gnt; v.a = a; v.we = we; v.be = be; v.wd = wd;
        v.chk_cd = chk_cd; v.cd = cd; v.chk_dd = chk_dd; v.dd = dd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare read returns due this cycle; debug rvalid must be low otherwise.
    task automatic chk_returns();
        bit dbg_due;
        dbg_due = 1'b0;
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            sb_t it;
            it = sbq.pop_front();
            if (it.is_dbg) begin
                dbg_due = 1'b1;
                chk("dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
                chk("dbg_rdata", dbg_rdata, it.data);
            end else begin
                chk("core_rdata", core_rdata, it.data);
            end
        end
        if (!dbg_due) chk("dbg_rvalid_idle", {31'b0, dbg_rvalid}, 32'd0);
    endtask

    task automatic drive(input logic creq, cwe, input logic [31:0] caddr, cwd,
                         input logic dreq, dwe, dlock, input logic [31:0] daddr, dwd);
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd; core_be = 4'hF;
        dbg_req = dreq; dbg_we = dwe; dbg_lock = dlock; dbg_addr = daddr; dbg_wdata = dwd;
        dbg_be = 4'hF;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.creq, v.cwe, v.caddr, v.cwd, v.dreq, v.dwe, v.dlock, v.daddr, v.dwd);
        #1;
        chk_returns();
        chk($sformatf("v%0d core_stall", idx), {31'b0, core_stall}, {31'b0, v.stall});
        chk($sformatf("v%0d dbg_gnt", idx), {31'b0, dbg_gnt}, {31'b0, v.gnt});
        chk($sformatf("v%0d mem_a", idx), {22'b0, mem_a}, {22'b0, v.a});
        chk($sformatf("v%0d mem_we", idx), {31'b0, mem_we}, {31'b0, v.we});
        chk($sformatf("v%0d mem_be", idx), {28'b0, mem_be}, {28'b0, v.be});
        chk($sformatf("v%0d mem_wd", idx), mem_wd, v.wd);
        if (v.chk_cd) sbq.push_back('{cyc + 1, 1'b0, v.cd});
        if (v.chk_dd) sbq.push_back('{cyc + 1, 1'b1, v.dd});
        @(posedge clk);
        cyc++;
    endtask

    vec_t vt [29];

    initial begin
        // core store then loads (one with high address bits that must be truncated)
        vt[0]  = mk(1,1,'h10,'h12345678, 0,0,0,0,0, 0,0,'h10,1,'hF,'h12345678, 0,0,0,0);
        vt[1]  = mk(1,0,'h10,0, 0,0,0,0,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        vt[2]  = mk(1,0,'h1010,0, 0,0,0,0,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        vt[3]  = mk(1,0,'h10,0, 0,0,0,0,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        // debug-only write then read
        vt[4]  = mk(0,0,0,0, 1,1,0,'h20,'hDEADBEEF, 0,1,'h20,1,'hF,'hDEADBEEF, 0,0,0,0);
        vt[5]  = mk(0,0,0,0, 1,0,0,'h20,0, 0,1,'h20,0,'hF,0, 0,0,1,'hDEADBEEF);
        vt[6]  = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);
        // starvation: core wins 4 conflicts, debug wins the 5th, core again
        for (int i = 7; i <= 10; i++)
            vt[i] = mk(1,0,'h10,0, 1,0,0,'h20,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        vt[11] = mk(1,0,'h10,0, 1,0,0,'h20,0, 1,1,'h20,0,'hF,0, 0,0,1,'hDEADBEEF);
        vt[12] = mk(1,0,'h10,0, 1,0,0,'h20,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        vt[13] = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);
        // locked read-modify-write of 0x40 (0x41 -> 0x42) against a busy core
        vt[14] = mk(0,0,0,0, 1,1,0,'h40,'h41, 0,1,'h40,1,'hF,'h41, 0,0,0,0);
        for (int i = 15; i <= 18; i++)
            vt[i] = mk(1,0,'h10,0, 1,0,1,'h40,0, 0,0,'h10,0,'hF,0, 1,'h12345678,0,0);
        vt[19] = mk(1,0,'h10,0, 1,0,1,'h40,0, 1,1,'h40,0,'hF,0, 0,0,1,'h41);
        vt[20] = mk(1,0,'h10,0, 1,1,0,'h40,'h42, 1,1,'h40,1,'hF,'h42, 0,0,0,0);
        vt[21] = mk(1,0,'h40,0, 0,0,0,0,0, 0,0,'h40,0,'hF,0, 1,'h42,0,0);
        // same-address conflict: core store first, debug retry lands last
        vt[22] = mk(1,1,'h8,'h1111, 1,1,0,'h8,'h2222, 0,0,'h8,1,'hF,'h1111, 0,0,0,0);
        vt[23] = mk(0,0,0,0, 1,1,0,'h8,'h2222, 0,1,'h8,1,'hF,'h2222, 0,0,0,0);
        vt[24] = mk(1,0,'h8,0, 0,0,0,0,0, 0,0,'h8,0,'hF,0, 1,'h2222,0,0);
        vt[25] = mk(0,0,0,0, 1,0,0,'h8,0, 0,1,'h8,0,'hF,0, 0,0,1,'h2222);
        // locked debug goes idle: lock released, core wins the same cycle
        vt[26] = mk(0,0,0,0, 1,0,1,'h20,0, 0,1,'h20,0,'hF,0, 0,0,1,'hDEADBEEF);
        vt[27] = mk(1,0,'h20,0, 0,0,0,0,0, 0,0,'h20,0,'hF,0, 1,'hDEADBEEF,0,0);
        vt[28] = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);

        // reset state with both requesters active
        reset = 1'b1;
        drive(1,1,'h10,'h55, 1,1,1,'h20,'h66);
        #2;
        chk("rst core_stall", {31'b0, core_stall}, 32'd0);
        chk("rst dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("rst dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_a", {22'b0, mem_a}, 32'd0);
        chk("rst mem_wd", mem_wd, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0,0,0,0, 0,0,0,0,0);
        @(posedge clk);
        cyc++;

        for (int i = 0; i < 29; i++) apply(vt[i], i);

        // reset while locked with a debug read in flight
        @(negedge clk);
        drive(0,0,0,0, 1,0,1,'h20,0);
        #1;
        chk("ml dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b1;
        drive(1,0,'h10,0, 1,1,1,'h20,'h77);
        #1;
        chk("ml rst dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("ml rst dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("ml rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("ml rst dbg_rdata", dbg_rdata, 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        drive(1,0,'h10,0, 1,0,0,'h20,0);
        #1;
        chk("ml post core_stall", {31'b0, core_stall}, 32'd0);
        chk("ml post dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
        chk("ml post dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
        chk("ml post mem_a", {22'b0, mem_a}, 32'h10);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive(0,0,0,0, 0,0,0,0,0);

        chk("sb drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
